// File: rtl/btb_pkg.sv
// Shared BTB types: the in-flight prediction record and the sizing constants.
package btb_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            pred_valid;
    logic [XLEN-1:0] pred_target;
    logic            pred_taken;
  } pred_entry_t;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] value);
    return (value == '1) ? value : value + XLEN'(1);
  endfunction

endpackage

// File: rtl/btb_update_unit_if.sv
// Fetch-side push, execute-side resolve and BTB write/redirect bundle.
interface btb_update_unit_if;
  import btb_pkg::*;

  logic            fetchValid;
  logic            fetchReady;
  logic [XLEN-1:0] fetchPC;
  logic            predValid;
  logic [XLEN-1:0] predTarget;
  logic            predTaken;
  logic            exValid;
  logic            exReady;
  logic [XLEN-1:0] exPC;
  logic            exTaken;
  logic [XLEN-1:0] exTarget;
  logic            update;
  logic [XLEN-1:0] updatePC;
  logic [XLEN-1:0] updateTarget;
  logic            mispredicted;
  logic            redirect;
  logic [XLEN-1:0] redirectPC;
  logic            seqError;
  logic [XLEN-1:0] branchCount;
  logic [XLEN-1:0] mispredCount;

  modport master (
    output fetchValid, fetchPC, predValid, predTarget, predTaken,
    output exValid, exPC, exTaken, exTarget,
    input  fetchReady, exReady, update, updatePC, updateTarget, mispredicted,
    input  redirect, redirectPC, seqError, branchCount, mispredCount
  );

  modport slave (
    input  fetchValid, fetchPC, predValid, predTarget, predTaken,
    input  exValid, exPC, exTaken, exTarget,
    output fetchReady, exReady, update, updatePC, updateTarget, mispredicted,
    output redirect, redirectPC, seqError, branchCount, mispredCount
  );

endinterface

// File: rtl/btb_update_unit_pred_fifo.sv
// In-order queue of fetch-time predictions; flush drops every entry at once.
module pred_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  pred_entry_t push_data,
  input  logic        pop,
  output pred_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  pred_entry_t    mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/btb_update_unit.sv
// Resolves queued predictions against execute outcomes and drives BTB training,
// front-end redirect and resolve statistics.
module btb_update_unit
  import btb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  btb_update_unit_if.slave  bus
);

  pred_entry_t     head;
  pred_entry_t     push_entry;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            pred_hit;
  logic            dir_miss;
  logic            tgt_miss;
  logic            mispred;
  logic            flush;
  logic            write_btb;

  logic            update_q;
  logic [XLEN-1:0] update_pc_q;
  logic [XLEN-1:0] update_target_q;
  logic            mispredicted_q;
  logic            redirect_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic            seq_error_q;
  logic [XLEN-1:0] branch_count_q;
  logic [XLEN-1:0] mispred_count_q;

  always_comb begin
    push       = bus.fetchValid && !fifo_full;
    pop        = bus.exValid && !fifo_empty;
    pred_hit   = head.pred_valid && head.pred_taken;
    dir_miss   = (pred_hit != bus.exTaken);
    tgt_miss   = bus.exTaken && pred_hit && (head.pred_target != bus.exTarget);
    mispred    = dir_miss || tgt_miss;
    flush      = pop && mispred;
    write_btb  = pop && (bus.exTaken || head.pred_valid);
    push_entry = '{pc: bus.fetchPC, pred_valid: bus.predValid,
                   pred_target: bus.predTarget, pred_taken: bus.predTaken};
  end

  // A push alongside a mispredicting pop is younger wrong-path work, so drop it.
  pred_fifo #(.DEPTH(DEPTH)) u_pred_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push && !flush),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      update_q        <= 1'b0;
      update_pc_q     <= '0;
      update_target_q <= '0;
      mispredicted_q  <= 1'b0;
      redirect_q      <= 1'b0;
      redirect_pc_q   <= '0;
      seq_error_q     <= 1'b0;
      branch_count_q  <= '0;
      mispred_count_q <= '0;
    end else begin
      update_q       <= write_btb;
      mispredicted_q <= flush;
      redirect_q     <= flush;
      if (write_btb) begin
        update_pc_q     <= bus.exPC;
        update_target_q <= bus.exTaken ? bus.exTarget : head.pred_target;
      end
      if (flush) begin
        redirect_pc_q   <= bus.exTaken ? bus.exTarget : bus.exPC + XLEN'(INSTR_BYTES);
        mispred_count_q <= sat_inc(mispred_count_q);
      end
      if (pop) begin
        branch_count_q <= sat_inc(branch_count_q);
        if (bus.exPC != head.pc) begin
          seq_error_q <= 1'b1;
        end
      end
    end
  end

  assign bus.fetchReady   = !fifo_full;
  assign bus.exReady      = !fifo_empty;
  assign bus.update       = update_q;
  assign bus.updatePC     = update_pc_q;
  assign bus.updateTarget = update_target_q;
  assign bus.mispredicted = mispredicted_q;
  assign bus.redirect     = redirect_q;
  assign bus.redirectPC   = redirect_pc_q;
  assign bus.seqError     = seq_error_q;
  assign bus.branchCount  = branch_count_q;
  assign bus.mispredCount = mispred_count_q;

endmodule

// File: tb/tb_btb_update_unit.sv
// Bench for btb_update_unit: directed vector table, corner sequences and a
// randomized run, all checked against a queue-based prediction model.
module tb_btb_update_unit;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    bit          pv;
    logic [31:0] tgt;
    bit          tk;
  } model_entry_t;

  typedef struct {
    logic [31:0] fpc;
    bit          pv;
    logic [31:0] ptgt;
    bit          ptk;
    logic [31:0] epc;
    bit          etk;
    logic [31:0] etgt;
    bit          exp_update;
    bit          exp_mispred;
    bit          exp_redirect;
    logic [31:0] exp_update_target;
    logic [31:0] exp_redirect_pc;
  } test_vec_t;

  logic clk;
  logic rst;
  int   vec_count;
  int   miscompares;

  model_entry_t q[$];
  bit           m_update;
  logic [31:0]  m_update_pc;
  logic [31:0]  m_update_target;
  bit           m_mispred;
  bit           m_redirect;
  logic [31:0]  m_redirect_pc;
  bit           m_seq_error;
  logic [31:0]  m_branch_count;
  logic [31:0]  m_mispred_count;

  btb_update_unit_if bus ();

  btb_update_unit #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] sat_next(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Drives one cycle from a falling edge, advances the model at the rising
  // edge and compares every output at the next falling edge.
  task automatic apply_stimulus(input bit r, input bit fv, input logic [31:0] fpc,
                                input bit pv, input logic [31:0] ptgt, input bit ptk,
                                input bit ev, input logic [31:0] epc, input bit etk,
                                input logic [31:0] etgt);
    bit fready, eready, do_pop, do_push, miss, hit;
    model_entry_t h;
    fready = (q.size() < DEPTH);
    eready = (q.size() > 0);
    if (!r) begin
      check_output("fetchReady", 32'(bus.fetchReady), 32'(fready));
      check_output("exReady", 32'(bus.exReady), 32'(eready));
    end
    rst            = r;
    bus.fetchValid = fv;
    bus.fetchPC    = fpc;
    bus.predValid  = pv;
    bus.predTarget = ptgt;
    bus.predTaken  = ptk;
    bus.exValid    = ev;
    bus.exPC       = epc;
    bus.exTaken    = etk;
    bus.exTarget   = etgt;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_update = 0; m_update_pc = 0; m_update_target = 0; m_mispred = 0;
      m_redirect = 0; m_redirect_pc = 0; m_seq_error = 0;
      m_branch_count = 0; m_mispred_count = 0;
    end else begin
      do_pop  = ev && eready;
      do_push = fv && fready;
      miss    = 0;
      m_update   = 0;
      m_mispred  = 0;
      m_redirect = 0;
      if (do_pop) begin
        h    = q.pop_front();
        hit  = h.pv && h.tk;
        miss = (hit != etk) || (etk && hit && h.tgt != etgt);
        m_branch_count = sat_next(m_branch_count);
        if (epc != h.pc) m_seq_error = 1;
        if (etk || h.pv) begin
          m_update        = 1;
          m_update_pc     = epc;
          m_update_target = etk ? etgt : h.tgt;
        end
        if (miss) begin
          m_mispred       = 1;
          m_redirect      = 1;
          m_redirect_pc   = etk ? etgt : epc + 32'd4;
          m_mispred_count = sat_next(m_mispred_count);
          q.delete();
        end
      end
      if (do_push && !miss) q.push_back('{pc: fpc, pv: pv, tgt: ptgt, tk: ptk});
    end
    @(negedge clk);
    check_output("update", 32'(bus.update), 32'(m_update));
    check_output("mispredicted", 32'(bus.mispredicted), 32'(m_mispred));
    check_output("redirect", 32'(bus.redirect), 32'(m_redirect));
    check_output("updatePC", bus.updatePC, m_update_pc);
    check_output("updateTarget", bus.updateTarget, m_update_target);
    check_output("redirectPC", bus.redirectPC, m_redirect_pc);
    check_output("seqError", 32'(bus.seqError), 32'(m_seq_error));
    check_output("branchCount", bus.branchCount, m_branch_count);
    check_output("mispredCount", bus.mispredCount, m_mispred_count);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push_only(input logic [31:0] pc, input bit pv,
                           input logic [31:0] tgt, input bit tk);
    apply_stimulus(0, 1, pc, pv, tgt, tk, 0, 0, 0, 0);
  endtask

  test_vec_t vecs[7];

  initial begin
    logic [31:0] rpc, rtgt, epc;
    vec_count   = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.fetchValid = 0; bus.fetchPC = 0; bus.predValid = 0; bus.predTarget = 0;
    bus.predTaken = 0; bus.exValid = 0; bus.exPC = 0; bus.exTaken = 0; bus.exTarget = 0;

    vecs[0] = '{32'h000A0000, 0, 32'h0, 0, 32'h000A0000, 1, 32'h000B0000, 1, 1, 1, 32'h000B0000, 32'h000B0000};
    vecs[1] = '{32'h000A0020, 1, 32'h000B0020, 1, 32'h000A0020, 1, 32'h000B0020, 1, 0, 0, 32'h000B0020, 32'h0};
    vecs[2] = '{32'h000A0040, 1, 32'h000B0040, 1, 32'h000A0040, 1, 32'h000B0044, 1, 1, 1, 32'h000B0044, 32'h000B0044};
    vecs[3] = '{32'h000A0004, 0, 32'h0, 0, 32'h000A0004, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0};
    vecs[4] = '{32'h000A0060, 1, 32'h000B0060, 1, 32'h000A0060, 0, 32'h0, 1, 1, 1, 32'h000B0060, 32'h000A0064};
    vecs[5] = '{32'hFFFFFFFC, 1, 32'h000000B0, 1, 32'hFFFFFFFC, 0, 32'h0, 1, 1, 1, 32'h000000B0, 32'h00000000};
    vecs[6] = '{32'h000A0080, 1, 32'h000B0080, 0, 32'h000A0080, 0, 32'h0, 1, 0, 0, 32'h000B0080, 32'h0};

    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_output("reset_fetchReady", 32'(bus.fetchReady), 32'd1);
    check_output("reset_exReady", 32'(bus.exReady), 32'd0);

    foreach (vecs[i]) begin
      push_only(vecs[i].fpc, vecs[i].pv, vecs[i].ptgt, vecs[i].ptk);
      apply_stimulus(0, 0, 0, 0, 0, 0, 1, vecs[i].epc, vecs[i].etk, vecs[i].etgt);
      check_output($sformatf("vec%0d_update", i), 32'(bus.update), 32'(vecs[i].exp_update));
      check_output($sformatf("vec%0d_mispred", i), 32'(bus.mispredicted), 32'(vecs[i].exp_mispred));
      check_output($sformatf("vec%0d_redirect", i), 32'(bus.redirect), 32'(vecs[i].exp_redirect));
      if (vecs[i].exp_update) begin
        check_output($sformatf("vec%0d_updatePC", i), bus.updatePC, vecs[i].epc);
        check_output($sformatf("vec%0d_updateTarget", i), bus.updateTarget, vecs[i].exp_update_target);
      end
      if (vecs[i].exp_redirect)
        check_output($sformatf("vec%0d_redirectPC", i), bus.redirectPC, vecs[i].exp_redirect_pc);
    end
    check_output("table_branchCount", bus.branchCount, 32'd7);
    check_output("table_mispredCount", bus.mispredCount, 32'd4);

    // Fill past capacity, then flush with a mispredicting head plus a push.
    for (int i = 0; i < 5; i++) push_only(32'h00000100 + 32'(i * 4), 0, 0, 0);
    check_output("full_fetchReady", 32'(bus.fetchReady), 32'd0);
    apply_stimulus(0, 1, 32'h00000200, 0, 0, 0, 1, 32'h00000100, 1, 32'h00000300);
    check_output("flush_exReady", 32'(bus.exReady), 32'd0);
    check_output("flush_redirectPC", bus.redirectPC, 32'h00000300);
    check_output("flush_branchCount", bus.branchCount, 32'd8);

    // Out-of-order resolve is flagged and sticks.
    push_only(32'h000A0004, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 32'h000A0008, 0, 0);
    check_output("seq_update", 32'(bus.update), 32'd0);
    idle(3);
    check_output("seqError_sticky", 32'(bus.seqError), 32'd1);

    // Reset with entries queued and a pop presented in the same cycle.
    for (int i = 0; i < 3; i++) push_only(32'h00000400 + 32'(i * 4), 1, 32'h00000500, 1);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1, 32'h00000400, 0, 0);
    check_output("rst_update", 32'(bus.update), 32'd0);
    check_output("rst_seqError", 32'(bus.seqError), 32'd0);
    check_output("rst_exReady", 32'(bus.exReady), 32'd0);
    check_output("rst_branchCount", bus.branchCount, 32'd0);
    idle(1);

    for (int n = 0; n < 400; n++) begin
      rtgt = 32'h00001000 + 32'(4 * $urandom_range(0, 3));
      if (q.size() > 0 && $urandom_range(0, 9) != 0) epc = q[0].pc;
      else epc = {20'h0, 10'($urandom), 2'b00};
      rpc = {20'h0, 10'($urandom), 2'b00};
      apply_stimulus(0, ($urandom_range(0, 3) != 0), rpc, 1'($urandom), rtgt, 1'($urandom),
                     1'($urandom), epc, 1'($urandom),
                     32'h00001000 + 32'(4 * $urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/btb_update_unit.md
# btb_update_unit

Branch-resolution side of the BTB interface: records each fetch-time prediction (`valid`, `target`, `predictedTaken`) in an in-order in-flight queue, compares it with the actual outcome when the branch resolves in execute, and drives the BTB write port (`update`, `updatePC`, `updateTarget`, `mispredicted`) plus a front-end redirect. It sits between the execute stage and the `btb`, and closes the predictor training loop.

## Interface
- `DEPTH`, 4: in-flight prediction queue entries (power of 2, ≥2).
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `fetchValid` in 1: a branch prediction is offered this cycle.
- `fetchReady` out 1: queue not full; push occurs when `fetchValid && fetchReady`.
- `fetchPC` in 32: PC of predicted instruction.
- `predValid` in 1: BTB hit at fetch.
- `predTarget` in 32: BTB target at fetch.
- `predTaken` in 1: BTB direction at fetch.
- `exValid` in 1: a branch resolves this cycle (program order).
- `exReady` out 1: queue not empty; pop occurs when `exValid && exReady`.
- `exPC` in 32: PC of resolving branch.
- `exTaken` in 1: actual direction.
- `exTarget` in 32: actual taken target.
- `update` out 1: one-cycle BTB write strobe.
- `updatePC` out 32: BTB write PC.
- `updateTarget` out 32: BTB write target.
- `mispredicted` out 1: qualifies `update`; drives BTB 2-bit FSM.
- `redirect` out 1: one-cycle front-end flush/redirect.
- `redirectPC` out 32: correct next PC.
- `seqError` out 1: sticky; `exPC` ≠ head PC on a pop.
- `branchCount` out 32, `mispredCount` out 32: saturating resolve/mispredict counters.

## Operation
- Queue entry: {PC, predValid, predTarget, predTaken}; FIFO order, pointers wrap modulo `DEPTH`, count width log2(DEPTH)+1.
- Effective prediction: `predHit = predValid && predTaken`; predicted next PC = `predHit ? predTarget : PC+4`.
- On pop, compare with head:
  - direction miss: `predHit != exTaken`.
  - target miss: `exTaken && predHit && predTarget != exTarget`.
  - `mispred = direction miss || target miss`.
- BTB write: issued when `exTaken || predValid` (allocate on taken, train on any hit); `updatePC=exPC`, `updateTarget = exTaken ? exTarget : head.predTarget`, `mispredicted = mispred`. Not-taken branch missing in BTB → no write.
- Redirect on `mispred`: `redirectPC = exTaken ? exTarget : exPC+4` (32-bit wrap).
- Flush: a mispredicting pop empties the queue (pointers, count to 0) at the same edge; a push in that cycle is dropped (younger, wrong-path).
- `seqError` set when popped `exPC` ≠ head PC; comparison/update still proceeds with `exPC`.
- Counters: `branchCount` +1 per pop, `mispredCount` +1 per mispredicting pop; saturate at 0xFFFFFFFF.

## Timing
- Reset: queue empty, `fetchReady=1`, `exReady=0`, `update`/`mispredicted`/`redirect`/`seqError`=0, `updatePC`/`updateTarget`/`redirectPC`=0, counters 0. Reset mid-operation discards all in-flight entries and any pending strobe.
- `fetchReady`/`exReady` derive from registered count only (no same-cycle bypass): push into empty queue is poppable next cycle earliest.
- Pop at edge N → `update`, `mispredicted`, `redirect`, data outputs valid cycle N+1 (registered, one cycle); deasserted N+2 unless another pop at N+1. `updatePC`/`updateTarget` hold last value while `update=0`.
- Push and pop same cycle (non-flushing): both take effect, count unchanged; allowed when full (pop uses `exReady`, push uses pre-edge `fetchReady=0` → push not accepted when full).
- Back-to-back pops: one update per cycle, no bubbles.

## Structure
- `btb_pkg`: `pred_entry_t` struct, `INSTR_BYTES=4` constant, `XLEN=32`; shared with `btb`.
- Sub-module `pred_fifo` (parameterised sync FIFO of `pred_entry_t`, with `flush` input); compare/update/counter logic in top.

## Test plan
- Push {0x000A0000, miss}, resolve taken →0x000B0000 → N+1: `update=1`, `updatePC=0x000A0000`, `updateTarget=0x000B0000`, `mispredicted=1`, `redirectPC=0x000B0000`.
- Push {0x000A0020, hit, 0x000B0020, taken}, resolve taken 0x000B0020 → `update=1`, `mispredicted=0`, `redirect=0`; counters 1/0.
- Push hit taken target 0x000B0040, resolve taken 0x000B0044 → target miss: `mispredicted=1`, `redirectPC=0x000B0044`.
- Push 4 entries, `fetchReady=0`, 5th dropped; mispredict head while pushing → queue empty, `exReady=0` next cycle, counters reflect 1 pop.
- Push miss not-taken 0x000A0004, resolve not-taken → no `update`, no redirect; resolve with `exPC=0x000A0008` → `seqError=1` sticky until `rst`.
- Assert `rst` with 3 entries queued and pop in flight → next cycle all outputs at reset values, `update=0`.
